// File: rtl/otp_pkg.sv
// Shared definitions for the OTP column programming controller.
// Holds the command mode codes, the electrical level encodings of every
// array bias line, the controller state enum and the bias phase enum.
// No ports; imported by the interface, bias decoder and top module.
package otp_pkg;

    // Command modes; 2'b10 and 2'b11 are no-ops.
    localparam logic [1:0] MODE_READ  = 2'b00;
    localparam logic [1:0] MODE_WRITE = 2'b01;

    // Plate line levels, two bits per column.
    localparam logic [1:0] PL_GND  = 2'b00;
    localparam logic [1:0] PL_MID  = 2'b01;
    localparam logic [1:0] PL_READ = 2'b10;
    localparam logic [1:0] PL_HIGH = 2'b11;

    // Bit line levels.
    localparam logic BL_GND = 1'b0;
    localparam logic BL_MID = 1'b1;

    // NMOS word line levels.
    localparam logic WLN_MID = 1'b0;
    localparam logic WLN_GND = 1'b1;

    // PMOS word line levels.
    localparam logic WLP_HIGH = 1'b0;
    localparam logic WLP_MID  = 1'b1;

    // Supply path select.
    localparam logic PRG_READ  = 1'b0;
    localparam logic PRG_WRITE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PROG,
        ST_DISCH,
        ST_VERIFY,
        ST_READ,
        ST_NEXT,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_PROG,
        PH_READ
    } phase_e;

endpackage

// File: rtl/otp_column_prog_ctrl_if.sv
// Command/status bus of the OTP column controller.
// master: issues start/mode/column/data_in, observes busy/done/results.
// slave : the controller side.
//   start     - command strobe, accepted only while idle
//   mode      - 00 read, 01 write, others no-op
//   column    - target column
//   data_in   - bit i = 1 programs row i
//   busy/done - status; done is a one-cycle pulse
//   data_out  - read or verified bits
//   fail_mask - rows that never verified
//   error     - any fail or out-of-range column
interface otp_column_prog_ctrl_if #(
    parameter int A = 5,
    parameter int B = 5
);
    localparam int CW = (B > 1) ? $clog2(B) : 1;

    logic          start;
    logic [1:0]    mode;
    logic [CW-1:0] column;
    logic [A-1:0]  data_in;
    logic          busy;
    logic          done;
    logic [A-1:0]  data_out;
    logic [A-1:0]  fail_mask;
    logic          error;

    modport master (
        output start, mode, column, data_in,
        input  busy, done, data_out, fail_mask, error
    );

    modport slave (
        input  start, mode, column, data_in,
        output busy, done, data_out, fail_mask, error
    );

endinterface

// File: rtl/otp_bias_gen.sv
// Combinational decode of (phase, row, column) into the array bias lines.
//   phase - PH_IDLE / PH_PROG / PH_READ
//   row   - selected row
//   col   - selected column
//   pl    - plate lines, 2 bits per column
//   bl    - bit lines
//   wln   - NMOS word lines
//   wlp   - PMOS word lines
//   prg   - supply path select
module otp_bias_gen
    import otp_pkg::*;
#(
    parameter int A = 5,
    parameter int B = 5
) (
    input  phase_e                              phase,
    input  logic [((A > 1) ? $clog2(A) : 1)-1:0] row,
    input  logic [((B > 1) ? $clog2(B) : 1)-1:0] col,
    output logic [2*B-1:0]                      pl,
    output logic [B-1:0]                        bl,
    output logic [A-1:0]                        wln,
    output logic [A-1:0]                        wlp,
    output logic                                prg
);

    always_comb begin
        pl  = {B{PL_GND}};
        bl  = {B{BL_GND}};
        wln = {A{WLN_GND}};
        wlp = {A{WLP_MID}};
        prg = PRG_READ;
        case (phase)
            PH_PROG: begin
                prg = PRG_WRITE;
                // Unselected columns sit at MID to keep their cells unstressed.
                for (int j = 0; j < B; j++) begin
                    if (j == int'(col)) begin
                        pl[2*j +: 2] = PL_HIGH;
                        bl[j]        = BL_GND;
                    end else begin
                        pl[2*j +: 2] = PL_MID;
                        bl[j]        = BL_MID;
                    end
                end
                for (int i = 0; i < A; i++) begin
                    if (i == int'(row)) begin
                        wlp[i] = WLP_HIGH;
                        wln[i] = WLN_MID;
                    end
                end
            end
            PH_READ: begin
                for (int j = 0; j < B; j++) begin
                    if (j == int'(col)) begin
                        pl[2*j +: 2] = PL_READ;
                        bl[j]        = BL_MID;
                    end
                end
                for (int i = 0; i < A; i++) begin
                    if (i == int'(row)) begin
                        wlp[i] = WLP_MID;
                        wln[i] = WLN_MID;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/otp_column_prog_ctrl.sv
// OTP column controller: reads or programs one full column of an A x B
// antifuse array. Writes run program / discharge / verify with bounded
// retries per cell; reads sample the sense circuit once per row.
//   clk                 - rising-edge clock
//   reset               - synchronous, active-low
//   bus                 - command/status interface (slave side)
//   output_read_circuit - sense result, 1 = cell programmed
//   PL/BL/WLN/WLP/PRG   - array bias lines, decoded from registered state
//   read_active         - high during READ and VERIFY windows
module otp_column_prog_ctrl
    import otp_pkg::*;
#(
    parameter int A         = 5,
    parameter int B         = 5,
    parameter int PROG_CYC  = 4,
    parameter int READ_CYC  = 2,
    parameter int MAX_RETRY = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    otp_column_prog_ctrl_if.slave        bus,
    input  logic                         output_read_circuit,
    output logic [2*B-1:0]               PL,
    output logic [B-1:0]                 BL,
    output logic [A-1:0]                 WLN,
    output logic [A-1:0]                 WLP,
    output logic                         PRG,
    output logic                         read_active
);

    localparam int CW   = (B > 1) ? $clog2(B) : 1;
    localparam int RW   = (A > 1) ? $clog2(A) : 1;
    localparam int MAXC = (PROG_CYC > READ_CYC) ? PROG_CYC : READ_CYC;
    localparam int NW   = $clog2(MAXC + 1);
    localparam int TW   = $clog2(MAX_RETRY + 1);

    localparam logic [NW-1:0] PROG_LAST = NW'(PROG_CYC - 1);
    localparam logic [NW-1:0] READ_LAST = NW'(READ_CYC - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(A - 1);
    localparam logic [TW-1:0] ATT_MAX   = TW'(MAX_RETRY);

    state_e        state_q,     state_d;
    logic [RW-1:0] row_q,       row_d;
    logic [TW-1:0] attempt_q,   attempt_d;
    logic [NW-1:0] cnt_q,       cnt_d;
    logic [CW-1:0] col_q,       col_d;
    logic [A-1:0]  din_q,       din_d;
    logic          is_wr_q,     is_wr_d;
    logic [A-1:0]  data_out_q,  data_out_d;
    logic [A-1:0]  fail_mask_q, fail_mask_d;
    logic          error_q,     error_d;

    logic [RW-1:0] nxt_row;
    phase_e        phase;

    assign nxt_row = row_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        attempt_d   = attempt_q;
        cnt_d       = cnt_q;
        col_d       = col_q;
        din_d       = din_q;
        is_wr_d     = is_wr_q;
        data_out_d  = data_out_q;
        fail_mask_d = fail_mask_q;
        error_d     = error_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && (bus.mode == MODE_READ || bus.mode == MODE_WRITE)) begin
                    col_d       = bus.column;
                    din_d       = bus.data_in;
                    is_wr_d     = (bus.mode == MODE_WRITE);
                    row_d       = '0;
                    attempt_d   = TW'(1);
                    cnt_d       = '0;
                    data_out_d  = '0;
                    fail_mask_d = '0;
                    error_d     = 1'b0;
                    if (int'(bus.column) >= B) begin
                        // Out-of-range column: finish without touching the array.
                        error_d = 1'b1;
                        state_d = ST_DONE;
                    end else if (bus.mode == MODE_READ) begin
                        state_d = ST_READ;
                    end else if (bus.data_in[0]) begin
                        state_d = ST_PROG;
                    end else begin
                        state_d = ST_NEXT;
                    end
                end
            end
            ST_PROG: begin
                if (cnt_q == PROG_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DISCH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DISCH: begin
                cnt_d   = '0;
                state_d = ST_VERIFY;
            end
            ST_VERIFY: begin
                if (cnt_q == READ_LAST) begin
                    cnt_d = '0;
                    if (output_read_circuit) begin
                        data_out_d[row_q] = 1'b1;
                        state_d           = ST_NEXT;
                    end else if (attempt_q < ATT_MAX) begin
                        attempt_d = attempt_q + 1'b1;
                        state_d   = ST_PROG;
                    end else begin
                        fail_mask_d[row_q] = 1'b1;
                        state_d            = ST_NEXT;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_READ: begin
                if (cnt_q == READ_LAST) begin
                    cnt_d             = '0;
                    data_out_d[row_q] = output_read_circuit;
                    state_d           = ST_NEXT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_NEXT: begin
                attempt_d = TW'(1);
                if (row_q == ROW_LAST) begin
                    error_d = |fail_mask_q;
                    state_d = ST_DONE;
                end else begin
                    row_d = nxt_row;
                    // Rows with nothing to program cost a single NEXT cycle.
                    if (!is_wr_q)            state_d = ST_READ;
                    else if (din_q[nxt_row]) state_d = ST_PROG;
                    else                     state_d = ST_NEXT;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            row_q       <= '0;
            attempt_q   <= '0;
            cnt_q       <= '0;
            col_q       <= '0;
            din_q       <= '0;
            is_wr_q     <= 1'b0;
            data_out_q  <= '0;
            fail_mask_q <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            attempt_q   <= attempt_d;
            cnt_q       <= cnt_d;
            col_q       <= col_d;
            din_q       <= din_d;
            is_wr_q     <= is_wr_d;
            data_out_q  <= data_out_d;
            fail_mask_q <= fail_mask_d;
            error_q     <= error_d;
        end
    end

    // DISCH, NEXT and DONE all fall through to idle bias.
    always_comb begin
        phase = PH_IDLE;
        case (state_q)
            ST_PROG:   phase = PH_PROG;
            ST_VERIFY: phase = PH_READ;
            ST_READ:   phase = PH_READ;
            default:   phase = PH_IDLE;
        endcase
    end

    otp_bias_gen #(
        .A (A),
        .B (B)
    ) u_bias (
        .phase (phase),
        .row   (row_q),
        .col   (col_q),
        .pl    (PL),
        .bl    (BL),
        .wln   (WLN),
        .wlp   (WLP),
        .prg   (PRG)
    );

    assign read_active   = (state_q == ST_READ) || (state_q == ST_VERIFY);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.data_out  = data_out_q;
    assign bus.fail_mask = fail_mask_q;
    assign bus.error     = error_q;

endmodule

// File: tb/tb_otp_column_prog_ctrl.sv
// Directed bench for otp_column_prog_ctrl (A=5, B=5, PROG_CYC=4,
// READ_CYC=2, MAX_RETRY=3). Each task drives one scenario and checks
// the outputs against hand-computed values.
module tb_otp_column_prog_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sense = 1'b0;
    logic [9:0] pl;
    logic [4:0] bl, wln, wlp;
    logic       prg, read_active;

    int vectors = 0;
    int miscompares = 0;

    // Per-operation tallies gathered by run_op.
    int   prog_cells [5][5];
    int   prg_cycles;
    int   prog_pulses;
    logic prev_prg;
    logic [9:0] snap_pl;
    logic [4:0] snap_bl, snap_wln, snap_wlp;
    logic       snap_prg, snap_busy, snap_ra;

    otp_column_prog_ctrl_if #(.A(5), .B(5)) bus ();

    otp_column_prog_ctrl #(
        .A(5), .B(5), .PROG_CYC(4), .READ_CYC(2), .MAX_RETRY(3)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .bus                 (bus),
        .output_read_circuit (sense),
        .PL                  (pl),
        .BL                  (bl),
        .WLN                 (wln),
        .WLP                 (wlp),
        .PRG                 (prg),
        .read_active         (read_active)
    );

    always #5 clk = ~clk;

    // Sense for cycle n after accept: constant, or one bit per 3-cycle read row.
    task automatic set_sense(input int n, input logic [4:0] pat, input bit per_row);
        int idx;
        if (per_row) begin
            idx = (n - 1) / 3;
            sense = (idx < 5) ? pat[idx] : 1'b0;
        end else begin
            sense = pat[0];
        end
    endtask

    // Issue a command and follow it until done; done_cyc = 0 on timeout.
    task automatic run_op(input logic [1:0] m, input logic [2:0] c, input logic [4:0] d,
                          input logic [4:0] pat, input bit per_row, output int done_cyc);
        for (int r = 0; r < 5; r++)
            for (int k = 0; k < 5; k++) prog_cells[r][k] = 0;
        prg_cycles = 0; prog_pulses = 0; prev_prg = 1'b0; done_cyc = 0;
        @(negedge clk);
        bus.mode = m; bus.column = c; bus.data_in = d; bus.start = 1'b1;
        set_sense(1, pat, per_row);
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (n == 1) begin
                snap_pl = pl; snap_bl = bl; snap_wln = wln; snap_wlp = wlp;
                snap_prg = prg; snap_busy = bus.busy; snap_ra = read_active;
            end
            if (prg) prg_cycles++;
            if (prg && !prev_prg) prog_pulses++;
            prev_prg = prg;
            for (int r = 0; r < 5; r++)
                for (int k = 0; k < 5; k++)
                    if (prg && wlp[r] == 1'b0 && wln[r] == 1'b0 &&
                        pl[2*k +: 2] == 2'b11 && bl[k] == 1'b0)
                        prog_cells[r][k]++;
            if (bus.done) begin
                done_cyc = n;
                break;
            end
            set_sense(n + 1, pat, per_row);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; bus.start = 1'b0; bus.mode = 2'b00; bus.column = 3'd0; bus.data_in = 5'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++; if (pl !== 10'h000) begin miscompares++; $display("FAIL reset_pl got %h want %h", pl, 10'h000); end
        vectors++; if (bl !== 5'b00000) begin miscompares++; $display("FAIL reset_bl got %b want %b", bl, 5'b00000); end
        vectors++; if (wln !== 5'b11111) begin miscompares++; $display("FAIL reset_wln got %b want %b", wln, 5'b11111); end
        vectors++; if (wlp !== 5'b11111) begin miscompares++; $display("FAIL reset_wlp got %b want %b", wlp, 5'b11111); end
        vectors++; if (prg !== 1'b0) begin miscompares++; $display("FAIL reset_prg got %b want 0", prg); end
        vectors++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_status busy %b done %b want 0 0", bus.busy, bus.done); end
        vectors++; if (bus.data_out !== 5'd0 || bus.fail_mask !== 5'd0 || bus.error !== 1'b0) begin miscompares++; $display("FAIL reset_results got %b %b %b want 0", bus.data_out, bus.fail_mask, bus.error); end
        reset = 1'b1;
    endtask

    task automatic test_write_first_pass;
        int dc;
        run_op(2'b01, 3'd2, 5'b00011, 5'b11111, 1'b0, dc);
        vectors++; if (dc !== 20) begin miscompares++; $display("FAIL wr_done_cycle got %0d want 20", dc); end
        vectors++; if (snap_prg !== 1'b1 || snap_busy !== 1'b1) begin miscompares++; $display("FAIL wr_first_prg_busy got %b %b want 1 1", snap_prg, snap_busy); end
        vectors++; if (snap_pl !== 10'h175) begin miscompares++; $display("FAIL wr_prog_pl got %h want %h", snap_pl, 10'h175); end
        vectors++; if (snap_bl !== 5'b11011) begin miscompares++; $display("FAIL wr_prog_bl got %b want %b", snap_bl, 5'b11011); end
        vectors++; if (snap_wln !== 5'b11110 || snap_wlp !== 5'b11110) begin miscompares++; $display("FAIL wr_prog_wl got wln %b wlp %b want 11110 11110", snap_wln, snap_wlp); end
        vectors++; if (prog_cells[0][2] !== 4 || prog_cells[1][2] !== 4) begin miscompares++; $display("FAIL wr_cell_cycles got %0d %0d want 4 4", prog_cells[0][2], prog_cells[1][2]); end
        vectors++; if (prg_cycles !== 8) begin miscompares++; $display("FAIL wr_total_prg got %0d want 8", prg_cycles); end
        vectors++; if (bus.data_out !== 5'b00011 || bus.fail_mask !== 5'b00000 || bus.error !== 1'b0) begin miscompares++; $display("FAIL wr_results got %b %b %b want 00011 00000 0", bus.data_out, bus.fail_mask, bus.error); end
    endtask

    task automatic test_write_stuck;
        int dc;
        run_op(2'b01, 3'd0, 5'b00001, 5'b00000, 1'b0, dc);
        vectors++; if (dc !== 27) begin miscompares++; $display("FAIL stuck_done_cycle got %0d want 27", dc); end
        vectors++; if (prog_pulses !== 3) begin miscompares++; $display("FAIL stuck_pulses got %0d want 3", prog_pulses); end
        vectors++; if (prog_cells[0][0] !== 12 || prg_cycles !== 12) begin miscompares++; $display("FAIL stuck_cell_cycles got %0d/%0d want 12/12", prog_cells[0][0], prg_cycles); end
        vectors++; if (bus.fail_mask !== 5'b00001 || bus.error !== 1'b1 || bus.data_out !== 5'b00000) begin miscompares++; $display("FAIL stuck_results got fm %b err %b do %b want 00001 1 00000", bus.fail_mask, bus.error, bus.data_out); end
    endtask

    task automatic test_read;
        int dc;
        run_op(2'b00, 3'd4, 5'd0, 5'b00101, 1'b1, dc);
        vectors++; if (dc !== 16) begin miscompares++; $display("FAIL rd_done_cycle got %0d want 16", dc); end
        vectors++; if (snap_pl !== 10'h200 || snap_bl !== 5'b10000) begin miscompares++; $display("FAIL rd_bias_pl_bl got %h %b want 200 10000", snap_pl, snap_bl); end
        vectors++; if (snap_wln !== 5'b11110 || snap_wlp !== 5'b11111 || snap_prg !== 1'b0 || snap_ra !== 1'b1) begin miscompares++; $display("FAIL rd_bias_wl got %b %b %b %b want 11110 11111 0 1", snap_wln, snap_wlp, snap_prg, snap_ra); end
        vectors++; if (prg_cycles !== 0) begin miscompares++; $display("FAIL rd_no_prog got %0d want 0", prg_cycles); end
        vectors++; if (bus.data_out !== 5'b00101 || bus.fail_mask !== 5'd0 || bus.error !== 1'b0) begin miscompares++; $display("FAIL rd_results got %b %b %b want 00101 00000 0", bus.data_out, bus.fail_mask, bus.error); end
    endtask

    task automatic test_bad_column;
        int dc;
        run_op(2'b01, 3'd7, 5'b11111, 5'b11111, 1'b0, dc);
        vectors++; if (dc !== 1) begin miscompares++; $display("FAIL badcol_done_cycle got %0d want 1", dc); end
        vectors++; if (bus.error !== 1'b1 || bus.data_out !== 5'd0) begin miscompares++; $display("FAIL badcol_results got err %b do %b want 1 00000", bus.error, bus.data_out); end
        vectors++; if (prg_cycles !== 0 || snap_pl !== 10'h000 || snap_bl !== 5'd0) begin miscompares++; $display("FAIL badcol_bias got prg %0d pl %h bl %b want 0 000 00000", prg_cycles, snap_pl, snap_bl); end
    endtask

    task automatic test_mid_reset_and_busy_start;
        int  dones, first_done;
        bit  after_done;
        // Reset while programming.
        @(negedge clk);
        bus.mode = 2'b01; bus.column = 3'd1; bus.data_in = 5'b00001; bus.start = 1'b1; sense = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk); @(negedge clk);
        vectors++; if (prg !== 1'b1) begin miscompares++; $display("FAIL midrst_in_prog got %b want 1", prg); end
        reset = 1'b0;
        @(negedge clk);
        vectors++; if (prg !== 1'b0 || pl !== 10'h000 || bl !== 5'd0 || wln !== 5'b11111 || wlp !== 5'b11111) begin miscompares++; $display("FAIL midrst_bias got prg %b pl %h bl %b wln %b wlp %b want idle", prg, pl, bl, wln, wlp); end
        vectors++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin miscompares++; $display("FAIL midrst_status got busy %b done %b want 0 0", bus.busy, bus.done); end
        reset = 1'b1;
        // New write with start held high while busy and through DONE.
        @(negedge clk);
        bus.mode = 2'b01; bus.column = 3'd3; bus.data_in = 5'b00010; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.mode = 2'b00; bus.column = 3'd0;
        dones = 0; first_done = 0; after_done = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (after_done) begin
                after_done = 1'b0;
                bus.start = 1'b0;
                vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL busy_start_done_ignored got busy %b want 0", bus.busy); end
            end
            if (bus.done) begin
                dones++;
                if (first_done == 0) begin
                    first_done = n;
                    after_done = 1'b1;
                    vectors++; if (bus.data_out !== 5'b00010) begin miscompares++; $display("FAIL busy_start_data got %b want 00010", bus.data_out); end
                end
            end
        end
        bus.start = 1'b0;
        vectors++; if (first_done !== 13) begin miscompares++; $display("FAIL busy_start_done_cycle got %0d want 13", first_done); end
        vectors++; if (dones !== 1) begin miscompares++; $display("FAIL busy_start_done_count got %0d want 1", dones); end
    endtask

    initial begin
        test_reset();
        test_write_first_pass();
        test_write_stuck();
        test_read();
        test_bad_column();
        test_mid_reset_and_busy_start();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/otp_column_prog_ctrl.md
# otp_column_prog_ctrl

Parametrised OTP column controller, the successor to the single-cell write/read FSM. It programs or reads one full column of an A×B antifuse array. Writes run a bit-serial program / discharge / read-back-verify loop with bounded retries, replacing the external `writing_successful` strobe. The block drives the array bias lines (PL, BL, WLN, WLP, PRG) and senses through the shared read circuit.

## Interface
Parameters:
- `A`, 5: rows; width of data and masks.
- `B`, 5: columns.
- `PROG_CYC`, 4: cycles per program pulse (≥1).
- `READ_CYC`, 2: cycles per read/verify window (≥1); sense sampled in last cycle.
- `MAX_RETRY`, 3: program attempts per cell before failure (≥1).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low.
- `start` in 1: command strobe, accepted only in IDLE.
- `mode` in 2: 00 read, 01 write, 10/11 no-op.
- `column` in $clog2(B): target column, sampled with `start`.
- `data_in` in A: bit i = 1 means program row i.
- `output_read_circuit` in 1: sense result, 1 = cell programmed.
- `PL` out 2B: plate line, 2 bits per column (`PL[2j+:2]`).
- `BL` out B: bit lines.
- `WLN` out A: NMOS word lines.
- `WLP` out A: PMOS word lines.
- `PRG` out 1: 1 = program supply path.
- `read_active` out 1: high in READ/VERIFY.
- `busy` out 1: high from the cycle after accept through DONE.
- `done` out 1: one-cycle pulse in DONE.
- `data_out` out A: read or verified bits, valid from `done` until the next accept.
- `fail_mask` out A: rows that failed verify, valid with `data_out`.
- `error` out 1: `|fail_mask`, or bad column; valid with `done`.

## Operation
- **Encodings.** PL: GND 00, MID 01, READ 10, HIGH 11. BL: GND 0, MID 1. WLN: MID 0, GND 1. WLP: HIGH 0, MID 1. PRG: read 0, write 1.
- **Idle bias.** All PL GND, all BL GND, all WLN GND, all WLP MID, PRG 0.
- **Program bias, row r / column c.** PRG 1. WLP[r] HIGH, WLN[r] MID. PL[c] HIGH, BL[c] GND. Unselected columns PL MID, BL MID. Unselected rows WLP MID, WLN GND.
- **Read/verify bias, row r / column c.** PRG 0. WLP[r] MID, WLN[r] MID. PL[c] READ, BL[c] MID. All other lines at idle bias.
- **States.** IDLE, PROG, DISCH, VERIFY, READ, NEXT, DONE.
- **Accept.** IDLE and `start` and mode ∈ {00, 01}: latch `column` and `data_in`, set row=0, attempt=1, clear `data_out` and `fail_mask`.
- **No-op modes.** `start` with mode 10/11 is ignored.
- **Bad column.** `column` ≥ B goes directly to DONE with `error`=1, `data_out`=0, and no bias applied.
- **Write.**
  - For row r with bit 0: NEXT.
  - For row r with bit 1: PROG (PROG_CYC) → DISCH (1 cycle, idle bias) → VERIFY (READ_CYC).
  - Sense 1: set `data_out[r]`, go to NEXT.
  - Sense 0 with attempt < MAX_RETRY: attempt++, return to PROG.
  - Sense 0 otherwise: set `fail_mask[r]`, go to NEXT.
- **Read.** Per row: READ (READ_CYC), `data_out[r]` = sense, then NEXT.
- **NEXT.** One cycle, idle bias. attempt=1. If r = A−1, go to DONE; otherwise r++.
- **DONE.** One cycle; `done`=1, `busy`=1, then IDLE.
- **Reset.** Reset asserted in any state → IDLE on the next edge. All outputs then take idle bias, and `busy`, `done`, `data_out`, `fail_mask`, `error` = 0. No partial bias survives.

## Timing
- All outputs are registered or decoded from registered state. No combinational input-to-output path.
- Accept at edge k: `busy`=1 and the first phase bias appear after edge k.
- Read latency: A·(READ_CYC+1) cycles, then 1 DONE cycle.
- Write, per bit-1 row: n·(PROG_CYC+1+READ_CYC) + 1 cycles, where n = attempts used. Bit-0 row: 1 cycle.
- `start` while `busy` is ignored. A `start` in the DONE cycle is ignored; a new `start` is accepted in IDLE on the cycle after DONE.
- Sense is sampled on the last READ/VERIFY cycle only. Earlier values are don't-care.

## Structure
- Package `otp_pkg`: mode codes, all PL/BL/WLN/WLP/PRG level constants, and the state enum. Shared with the legacy FSM bench checker.
- Sub-module `otp_bias_gen`: combinational decode of (phase ∈ {idle, prog, read}, row, column) to PL/BL/WLN/WLP/PRG.
- The top module holds the FSM, the phase/attempt/row counters, and the output registers.

## Test plan
- **Reset.** Hold `reset`=0 for 2 cycles → idle bias: PL=0, BL=0, WLN=all 1s, WLP=all 1s, PRG=0, `busy`=0.
- **Write, first-pass verify.** Write column 2, `data_in`=5'b00011, sense returns 1 on first verify → exactly cells [0][2] and [1][2] see program bias for 4 cycles each. `done` 20 cycles after accept; `data_out`=00011, `fail_mask`=0.
- **Write, stuck cell.** Write row 0, sense stuck at 0 → 3 program pulses, `fail_mask[0]`=1, `error`=1.
- **Read.** Read column 4 with sense pattern 1,0,1,0,0 → `data_out`=5'b00101 after 15 cycles plus DONE.
- **Bad column.** `column`=7 with B=5 → `done` next cycle, `error`=1, no program bias ever asserted.
- **Mid-operation reset and ignored start.** Reset during PROG → idle bias next edge. `start` while `busy` → ignored, no second `done`.
